// File: rtl/usb_tx_timer_gen.sv
// Bit/byte timing generator for the USB transmit path: bit-period strobe,
// per-byte load strobe, byte counter and end-of-data strobe with bit-stuff support.
module usb_tx_timer_gen #(
    parameter int unsigned CLKS_PER_BIT  = 8,
    parameter int unsigned BITS_PER_BYTE = 8,
    parameter int unsigned LEN_BITS      = 8
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             tim_rst,
    input  logic                             tim_en,
    input  logic                             start,
    input  logic [LEN_BITS-1:0]              byte_len,
    input  logic                             stuff_req,
    output logic                             busy,
    output logic                             new_bit,
    output logic                             stuffed,
    output logic                             load_byte,
    output logic [$clog2(BITS_PER_BYTE)-1:0] bit_idx,
    output logic [LEN_BITS-1:0]              byte_out,
    output logic                             eod
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(BITS_PER_BYTE);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    width_q, width_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LEN_BITS-1:0] byte_q, byte_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic                zeod_q, zeod_d;

    logic tick;
    logic last_bit;
    logic last_byte;

    // State and counter registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            width_q <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            len_q   <= '0;
            zeod_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            len_q   <= len_d;
            zeod_q  <= zeod_d;
        end
    end

    // Strobes decode from registered state; tim_rst masks them so a clear never emits eod
    always_comb begin
        tick      = (state_q == RUN) && tim_en && !tim_rst
                    && (width_q == CNT_W'(CLKS_PER_BIT - 1));
        last_bit  = tick && !stuff_req && (idx_q == IDX_W'(BITS_PER_BYTE - 1));
        last_byte = last_bit && (byte_q == len_q - LEN_BITS'(1));
    end

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        width_d = width_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        len_d   = len_q;
        zeod_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    byte_d = '0;
                    if (byte_len != '0) begin
                        len_d   = byte_len;
                        width_d = '0;
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        zeod_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (tim_en) begin
                    width_d = (width_q == CNT_W'(CLKS_PER_BIT - 1)) ? '0 : width_q + CNT_W'(1);
                end
                // Stuffed periods leave the data-bit position untouched
                if (tick && !stuff_req) begin
                    idx_d = last_bit ? '0 : idx_q + IDX_W'(1);
                end
                if (last_bit) begin
                    byte_d = byte_q + LEN_BITS'(1);
                end
                if (last_byte) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (tim_rst) begin
            state_d = IDLE;
            width_d = '0;
            idx_d   = '0;
            byte_d  = '0;
            len_d   = '0;
            zeod_d  = 1'b0;
        end
    end

    assign busy      = (state_q == RUN);
    assign new_bit   = tick;
    assign stuffed   = tick && stuff_req;
    assign load_byte = last_bit;
    assign eod       = last_byte || zeod_q;
    assign bit_idx   = idx_q;
    assign byte_out  = byte_q;

endmodule

// File: doc/usb_tx_timer_gen.md
Name: usb_tx_timer_gen

Overview:
- Parametrised bit/byte timing generator for the USB transmit path.
- Produces a bit-period strobe, a per-byte load strobe, a running byte index and an end-of-data (EOD) strobe.
- Differs from the fixed 8-clock / 8-bit / 64-byte timer in three ways: bit width and byte size are parameters, packet length is a runtime input latched at start, and the timer supports bit-stuff periods that do not advance the data-bit count.
- Sits between the transmit controller FSM and the NRZI/bit-stuff encoder.

Parameters:
- CLKS_PER_BIT, 8, enabled clock cycles per USB bit period (>=2).
- BITS_PER_BYTE, 8, data bits per byte before load_byte fires (>=2).
- LEN_BITS, 8, width of the byte-length input and the byte_out counter.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- tim_rst  in  1  synchronous clear; overrides everything except n_rst.
- tim_en  in  1  clock-period enable; width counter advances only when high.
- start  in  1  single-cycle request to begin a packet.
- byte_len  in  LEN_BITS  number of bytes in the packet; sampled on accepted start.
- stuff_req  in  1  current bit period is a stuffed bit; sampled on new_bit cycle.
- busy  out  1  high while in RUN.
- new_bit  out  1  one-cycle strobe at the end of each bit period.
- stuffed  out  1  one-cycle strobe: this bit period was a stuffed bit.
- load_byte  out  1  one-cycle strobe: last data bit of a byte completed.
- bit_idx  out  clog2(BITS_PER_BYTE)  index of the current data bit within the byte.
- byte_out  out  LEN_BITS  count of bytes completed in the current packet.
- eod  out  1  one-cycle strobe: packet complete.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on n_rst.
- Reset values (n_rst low): state=IDLE; width_cnt, bit_idx, byte_out, len_reg = 0; all strobes low; busy low.
- States:
  - IDLE: counters hold. byte_out holds the last packet's final count.
  - start with byte_len!=0: latch len_reg=byte_len, clear width_cnt, bit_idx and byte_out, go to RUN next cycle.
  - start with byte_len==0: eod pulses next cycle, stay IDLE, byte_out cleared to 0.
  - RUN: start is ignored.
- Width counter (RUN and tim_en=1 only):
  - Increments, wrapping 0..CLKS_PER_BIT-1.
  - new_bit = RUN & tim_en & (width_cnt==CLKS_PER_BIT-1); combinational from registered state.
  - The first new_bit occurs on the CLKS_PER_BIT-th enabled cycle after entering RUN.
  - tim_en low freezes width_cnt; no strobes fire.
- On a new_bit cycle with stuff_req=1:
  - stuffed=1; bit_idx, byte_out and load_byte are unaffected.
- On a new_bit cycle with stuff_req=0:
  - bit_idx increments.
  - If bit_idx==BITS_PER_BYTE-1: bit_idx wraps to 0, load_byte=1 in the same cycle, byte_out increments next edge.
  - If load_byte and byte_out==len_reg-1: eod=1 in the same cycle, state goes to IDLE, byte_out ends at len_reg.
- On the final bit, new_bit, load_byte and eod are all high in one cycle.
- stuff_req outside new_bit cycles is ignored.
- tim_rst=1: next edge forces IDLE and clears all counters and byte_out. A simultaneous start is dropped.
- Wrap-around: byte_len = 2^LEN_BITS-1 is legal; byte_out reaches its maximum without overflow.
- byte_len changes during RUN have no effect (len_reg holds).
- n_rst low mid-packet: immediate return to reset values; no eod.

Test Plan:
- Reset, then start with byte_len=2 and tim_en=1 constantly (defaults):
  - new_bit every 8 cycles, first at cycle 8 after entry to RUN.
  - load_byte at bit 8 and bit 16; eod with the 16th new_bit.
  - byte_out 0→1→2; busy low the cycle after eod.
- byte_len=1, stuff_req=1 on the 3rd new_bit only:
  - stuffed pulses once.
  - load_byte and eod on the 9th new_bit (72 enabled clocks).
  - bit_idx holds 2 across the stuffed period.
- byte_len=1, tim_en toggling 1/0 each cycle:
  - new_bit spacing becomes 16 clocks.
  - eod after 128 clocks.
  - No strobes on tim_en=0 cycles.
- tim_rst asserted at byte_out=1, bit_idx=4 of a byte_len=3 packet:
  - Next cycle IDLE with all counters 0; no eod.
  - A start asserted the same cycle as tim_rst is ignored.
- start with byte_len=0:
  - eod one cycle later, busy never high.
  - A start during RUN with a different byte_len is ignored; the original length is honoured.
- Override CLKS_PER_BIT=4, BITS_PER_BYTE=5, LEN_BITS=4, byte_len=15:
  - load_byte every 20 clocks.
  - eod at clock 300; byte_out=15 held in IDLE.
